// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fir_pkg
// Brief   : Shared types and the product scaling helper for the FIR input
//           stage. Optional saturation is selected by the FIR_IN_SAT_EN macro
//           (defined: saturate, undefined: keep the low DATA_W bits).
// Revision: 1.0  initial release
// ============================================================================
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_PROD_W = 2 * FIR_DATA_W + 1;

  // Complex sample, real part in the upper half of the packed word
  typedef struct packed {
    logic signed [FIR_DATA_W-1:0] re;
    logic signed [FIR_DATA_W-1:0] im;
  } fir_cplx_t;

  // Full-precision conjugate-product component
  typedef logic signed [FIR_PROD_W-1:0] fir_prod_t;

  // Round half up, arithmetic shift right, then reduce to FIR_DATA_W bits.
  // One guard bit above the product keeps the rounding add from overflowing.
  function automatic logic signed [FIR_DATA_W-1:0] fir_scale(
    input fir_prod_t  i_p,
    input logic [7:0] i_shift
  );
    logic signed [FIR_PROD_W:0] w_v;
    logic [FIR_PROD_W:0]        w_rnd;
    w_v   = {i_p[FIR_PROD_W-1], i_p};
    w_rnd = '0;
    if (i_shift != 8'd0) begin
      w_rnd = {{FIR_PROD_W{1'b0}}, 1'b1} << (i_shift - 8'd1);
      w_v   = w_v + $signed(w_rnd);
      w_v   = w_v >>> i_shift;
    end
`ifdef FIR_IN_SAT_EN
    // Out of range when the bits above the result sign differ from the MSB
    if (w_v[FIR_PROD_W:FIR_DATA_W-1] != {(FIR_PROD_W-FIR_DATA_W+2){w_v[FIR_PROD_W]}}) begin
      return w_v[FIR_PROD_W] ? $signed({1'b1, {(FIR_DATA_W-1){1'b0}}})
                             : $signed({1'b0, {(FIR_DATA_W-1){1'b1}}});
    end
`endif
    return $signed(w_v[FIR_DATA_W-1:0]);
  endfunction

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_lag_buf.sv
`default_nettype none
// ============================================================================
// Module  : fir_lag_buf
// Brief   : Circular delay-line RAM, one write port and one registered read
//           port. Read-first: a read and write to the same address on the
//           same edge returns the previously stored word.
// Revision: 1.0  initial release
// ============================================================================
module fir_lag_buf #(
  parameter int AW    = 6,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array; the write commits alongside the read, so reads see old data
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read-data register, only updated when a read is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule : fir_lag_buf
`default_nettype wire

// File: rtl/fir_in_lag.sv
`default_nettype none
// ============================================================================
// Module  : fir_in_lag
// Brief   : FIR accelerator input stage. Cross mode forwards samples; auto
//           mode emits x[n]*conj(x[n-D]) scaled by cfg_shift. Two register
//           stages with a single ready/valid enable. Saturation of the scaled
//           result is enabled by defining FIR_IN_SAT_EN.
// Revision: 1.0  initial release
// ============================================================================
module fir_in_lag
  import fir_pkg::*;
#(
  parameter int DATA_W    = fir_pkg::FIR_DATA_W,
  parameter int MAX_DELAY = 64,
  parameter int SHIFT_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_auto,
  input  logic [$clog2(MAX_DELAY):0]   cfg_delay,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*DATA_W-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*DATA_W-1:0]          out_data,
  output logic                         primed
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam int DW = AW + 1;

  logic [AW-1:0]         r_wr_ptr;
  logic [DW-1:0]         r_fill_cnt;
  logic                  r_s1_valid;
  fir_cplx_t             r_s1_data;
  logic                  r_out_valid;
  logic [2*DATA_W-1:0]   r_out_data;

  logic                  w_en;
  logic                  w_accept;
  logic                  w_keep;
  logic [DW-1:0]         w_delay;
  logic [AW-1:0]         w_rd_addr;
  logic [2*DATA_W-1:0]   w_rd;
  fir_cplx_t             w_a;
  fir_cplx_t             w_b;
  logic signed [2*DATA_W-1:0] w_rr, w_ii, w_ir, w_ri;
  fir_prod_t             w_pre, w_pim;
  logic [2*DATA_W-1:0]   w_result;

  // Out-of-range lags (0 or above MAX_DELAY) fall back to the full depth
  assign w_delay = (cfg_delay == '0 || cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;

  assign w_en      = !r_out_valid | out_ready;
  assign in_ready  = w_en & !flush;
  assign w_accept  = in_valid & in_ready;
  // In auto mode a sample only produces output once D older samples exist
  assign w_keep    = !cfg_auto | (r_fill_cnt >= w_delay);
  // D = MAX_DELAY aliases onto the write address; the RAM is read-first
  assign w_rd_addr = r_wr_ptr - w_delay[AW-1:0];
  assign primed    = (r_fill_cnt == w_delay);

  fir_lag_buf #(
    .AW    (AW),
    .WIDTH (2*DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_re    (w_accept & cfg_auto),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd)
  );

  // Write pointer and fill count advance on every accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_fill_cnt < w_delay) r_fill_cnt <= r_fill_cnt + DW'(1);
    end
  end

  // Stage 1: input register, aligned with the buffer read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_accept & w_keep;
      if (w_accept) r_s1_data <= in_data;
    end
  end

  // Conjugate product a * conj(b), a = x[n], b = x[n-D]
  assign w_a   = r_s1_data;
  assign w_b   = w_rd;
  assign w_rr  = w_a.re * w_b.re;
  assign w_ii  = w_a.im * w_b.im;
  assign w_ir  = w_a.im * w_b.re;
  assign w_ri  = w_a.re * w_b.im;
  assign w_pre = {w_rr[2*DATA_W-1], w_rr} + {w_ii[2*DATA_W-1], w_ii};
  assign w_pim = {w_ir[2*DATA_W-1], w_ir} - {w_ri[2*DATA_W-1], w_ri};

  assign w_result = cfg_auto ? {fir_scale(w_pre, 8'(cfg_shift)), fir_scale(w_pim, 8'(cfg_shift))}
                             : r_s1_data;

  // Stage 2: output register, held while the downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_data <= w_result;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule : fir_in_lag
`default_nettype wire

// File: tb/tb_fir_in_lag.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_in_lag
// Brief   : Self-checking bench for fir_in_lag with a sample-history model.
// Revision: 1.0  initial release
// ============================================================================
module tb_fir_in_lag;

  localparam int DATA_W    = 16;
  localparam int MAX_DELAY = 64;
  localparam int SHIFT_W   = 5;
  localparam int DW        = $clog2(MAX_DELAY) + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_auto = 1'b0;
  logic [DW-1:0]        cfg_delay = DW'(1);
  logic [SHIFT_W-1:0]   cfg_shift = '0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [2*DATA_W-1:0]  in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [2*DATA_W-1:0]  out_data;
  logic                 primed;

  fir_in_lag #(.DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .cfg_auto(cfg_auto), .cfg_delay(cfg_delay),
    .cfg_shift(cfg_shift), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .primed(primed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: every sample accepted since the last clear
  logic [31:0] hist[$];
  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];
  bit          m_auto;
  int          m_d;
  int          m_shift;
  bit          held;
  logic [31:0] held_data;

  function automatic logic [31:0] cx(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  function automatic logic [15:0] scale_ref(input longint p, input int s);
    longint v;
    v = p;
    if (s > 0) v = (v + (longint'(1) <<< (s - 1))) >>> s;
`ifdef FIR_IN_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  function automatic logic [31:0] lag_ref(input logic [31:0] a, input logic [31:0] b);
    longint are, aim, bre, bim;
    are = longint'($signed(a[31:16]));
    aim = longint'($signed(a[15:0]));
    bre = longint'($signed(b[31:16]));
    bim = longint'($signed(b[15:0]));
    return {scale_ref(are * bre + aim * bim, m_shift), scale_ref(aim * bre - are * bim, m_shift)};
  endfunction

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
    held = 1'b0;
  endtask

  task automatic model_accept(input logic [31:0] d);
    hist.push_back(d);
    if (!m_auto) exp_q.push_back(d);
    else if (hist.size() > m_d) exp_q.push_back(lag_ref(d, hist[hist.size() - 1 - m_d]));
  endtask

  // One clock cycle: drive at the falling edge, check after settling
  task automatic step(input bit v, input logic [31:0] d, input bit rdy, input bit fl, output bit acc);
    logic [31:0] e;
    bit          exp_primed;
    bit          exp_rdy;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = rdy; flush = fl;
    #1;
    acc = 1'b0;
    exp_primed = (hist.size() >= m_d);
    checks++;
    if (primed !== exp_primed) begin
      errors++; $display("FAIL primed: got %b want %b", primed, exp_primed);
    end
    exp_rdy = (!out_valid || rdy) && !fl;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++; $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
    end
    if (held) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data) begin
        errors++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, held_data);
      end
    end
    if (exp_q.size() == 0) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL spurious_valid: got out_valid=%b want 0", out_valid);
      end
    end else if (out_valid && rdy) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e) begin
        errors++; $display("FAIL out_data: got %h want %h", out_data, e);
      end
    end
    held = out_valid && !rdy;
    held_data = out_data;
    if (fl) model_clear();
    else if (v && in_ready) begin
      acc = 1'b1;
      model_accept(d);
    end
  endtask

  task automatic drain();
    int cyc;
    bit acc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      step(1'b0, '0, 1'b1, 1'b0, acc);
      cyc++;
    end
    step(1'b0, '0, 1'b1, 1'b0, acc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  // Feed src_q with random (or patterned) valid/ready, then drain
  task automatic run_src(input int vpct, input int rpct, input bit pat);
    int cyc;
    bit v, r, acc;
    cyc = 0;
    while (src_q.size() > 0 && cyc < 2000) begin
      v = ($urandom_range(99) < vpct);
      r = pat ? ((cyc % 4) == 0 || (cyc % 4) == 3) : ($urandom_range(99) < rpct);
      step(v, src_q[0], r, 1'b0, acc);
      if (acc) src_q.delete(0);
      cyc++;
    end
    checks++;
    if (src_q.size() != 0) begin
      errors++; $display("FAIL feed_timeout: got %0d unsent want 0", src_q.size());
    end
    drain();
  endtask

  task automatic set_cfg(input bit a, input int d, input int s);
    bit acc;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    cfg_auto = a; cfg_delay = DW'(d); cfg_shift = SHIFT_W'(s);
    m_auto = a;
    m_d = (d == 0 || d > MAX_DELAY) ? MAX_DELAY : d;
    m_shift = s;
    model_clear();
    step(1'b0, '0, 1'b1, 1'b1, acc);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    m_auto = 1'b0; m_d = 1; m_shift = 0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++;
    if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed: got %b want 0", primed); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_auto_d3();
    set_cfg(1'b1, 3, 0);
    src_q = '{cx(1,0), cx(2,0), cx(3,0), cx(4,1), cx(5,0)};
    run_src(100, 100, 1'b0);
  endtask

  task automatic test_max_delay();
    set_cfg(1'b1, MAX_DELAY, 0);
    for (int n = 0; n < 80; n++) src_q.push_back(cx(n, 0));
    run_src(100, 100, 1'b0);
  endtask

  task automatic test_overflow();
    set_cfg(1'b1, 1, 0);
    for (int n = 0; n < 4; n++) src_q.push_back(cx(32767, 32767));
    run_src(100, 100, 1'b0);
  endtask

  task automatic test_rounding();
    set_cfg(1'b1, 1, 1);
    src_q = '{cx(1,0), cx(3,0), cx(-1,0)};
    run_src(100, 100, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_cfg(1'b0, 5, 0);
    for (int n = 0; n < 10; n++) src_q.push_back($urandom);
    run_src(100, 0, 1'b1);
  endtask

  task automatic test_flush();
    bit acc;
    set_cfg(1'b1, 4, 0);
    for (int n = 0; n < 5; n++) step(1'b1, $urandom, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++;
    if (primed !== 1'b0) begin errors++; $display("FAIL flush_primed: got %b want 0", primed); end
    for (int n = 0; n < 6; n++) src_q.push_back($urandom);
    run_src(100, 100, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit acc;
    set_cfg(1'b1, 2, 3);
    for (int n = 0; n < 6; n++) step(1'b1, $urandom, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || primed !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL async_reset: got v=%b p=%b d=%h want 0 0 0", out_valid, primed, out_data);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) src_q.push_back($urandom);
    run_src(100, 100, 1'b0);
  endtask

  task automatic test_random();
    int d_pick [6] = '{0, 1, 7, 33, 64, 100};
    for (int k = 0; k < 6; k++) begin
      set_cfg(1'($urandom_range(1)), d_pick[k], int'($urandom_range(31)));
      for (int n = 0; n < m_d + 40; n++) src_q.push_back($urandom);
      run_src(80, 70, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_auto_d3();
    test_max_delay();
    test_overflow();
    test_rounding();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fir_in_lag
`default_nettype wire
